// File: rtl/vga_timing_gen.sv
// Pixel/line timing generator with registered syncs, display enable and test patterns.
// Optional build macro: VGA_BORDER_EN adds a 1-pixel white border around the visible area.
module vga_timing_gen #(
  parameter int   HVIS = 256,
  parameter int   HFP  = 6,
  parameter int   HSW  = 39,
  parameter int   HBP  = 19,
  parameter int   VVIS = 480,
  parameter int   VFP  = 10,
  parameter int   VSW  = 2,
  parameter int   VBP  = 33,
  parameter logic HPOL = 1'b0,
  parameter logic VPOL = 1'b0,
  parameter int   CW   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  output logic [9:0]    hcnt,
  output logic [9:0]    vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          sof,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  localparam int HT = HVIS + HFP + HSW + HBP;
  localparam int VT = VVIS + VFP + VSW + VBP;
  localparam int HB = $clog2(HVIS);

  localparam logic [10:0] HT_LAST  = 11'(HT - 1);
  localparam logic [10:0] VT_LAST  = 11'(VT - 1);
  localparam logic [10:0] HVIS_L   = 11'(HVIS);
  localparam logic [10:0] VVIS_L   = 11'(VVIS);
  localparam logic [10:0] HS_START = 11'(HVIS + HFP);
  localparam logic [10:0] HS_END   = 11'(HVIS + HFP + HSW);
  localparam logic [10:0] VS_START = 11'(VVIS + VFP);
  localparam logic [10:0] VS_END   = 11'(VVIS + VFP + VSW);
`ifdef VGA_BORDER_EN
  localparam logic [10:0] H_EDGE   = 11'(HVIS - 1);
  localparam logic [10:0] V_EDGE   = 11'(VVIS - 1);
`endif

  if (HT > 1024) begin : g_ht_check
    $error("vga_timing_gen: total line length HT exceeds 1024");
  end
  if (VT > 1024) begin : g_vt_check
    $error("vga_timing_gen: total frame height VT exceeds 1024");
  end
  if ((HVIS < 64) || ((HVIS & (HVIS - 1)) != 0)) begin : g_hvis_check
    $error("vga_timing_gen: HVIS must be a power of two of at least 64");
  end
  if ((CW < 1) || (CW > 4)) begin : g_cw_check
    $error("vga_timing_gen: CW must be within 1..4");
  end

  logic [9:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, sof_q, sof_d;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic [10:0]   hx, vx;
  logic          atOrigin, lineEnd, frameEnd, visible;
  logic [2:0]    barBits;
  logic [CW-1:0] stripe, patR, patG, patB;

  always_comb begin
    hx       = {1'b0, hcnt_q};
    vx       = {1'b0, vcnt_q};
    atOrigin = (hcnt_q == '0) && (vcnt_q == '0);
    lineEnd  = (hx == HT_LAST);
    frameEnd = (vx == VT_LAST);

    hcnt_d = lineEnd ? '0 : hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (lineEnd) begin
      vcnt_d = frameEnd ? '0 : vcnt_q + 10'd1;
    end

    // Pixel (0,0) already uses the incoming mode so a whole frame shares one pattern.
    mode_d = atOrigin ? mode : mode_q;

    visible = (hx < HVIS_L) && (vx < VVIS_L);
    hsync_d = ((hx >= HS_START) && (hx < HS_END)) ? HPOL : ~HPOL;
    vsync_d = ((vx >= VS_START) && (vx < VS_END)) ? VPOL : ~VPOL;
    de_d    = visible;
    sof_d   = atOrigin;

    barBits = hcnt_q[HB-1 -: 3];
    stripe  = hcnt_q[CW+2:3] + vcnt_q[CW+3:4];
    patR    = '0;
    patG    = '0;
    patB    = '0;
    case (mode_d)
      2'd0: begin
        patR = {CW{barBits[2]}};
        patG = {CW{barBits[1]}};
        patB = {CW{barBits[0]}};
      end
      2'd1: begin
        if (hcnt_q[4] ^ vcnt_q[4]) begin
          patR = '1;
          patG = '1;
          patB = '1;
        end
      end
      2'd2: begin
        patR = stripe;
        patG = stripe;
        patB = stripe;
      end
      default: begin
        patR = '1;
        patG = '1;
        patB = '1;
      end
    endcase
`ifdef VGA_BORDER_EN
    if ((hx == '0) || (hx == H_EDGE) || (vx == '0) || (vx == V_EDGE)) begin
      patR = '1;
      patG = '1;
      patB = '1;
    end
`endif

    r_d = visible ? patR : '0;
    g_d = visible ? patG : '0;
    b_d = visible ? patB : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      mode_q  <= '0;
      hsync_q <= ~HPOL;
      vsync_q <= ~VPOL;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else if (en) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      mode_q  <= mode_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hcnt  = hcnt_q;
  assign vcnt  = vcnt_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign sof   = sof_q;
  assign r     = r_q;
  assign g     = g_q;
  assign b     = b_q;

endmodule
